// File: rtl/game_pkg.sv
// Shared state encoding, datapath widths and step-period helper for the
// game scheduler and its step timer.
package game_pkg;

   localparam int SCORE_W = 16;
   localparam int LEVEL_W = 4;
   localparam int CNT_W   = 17;
   localparam int FRAME_W = 16;

   localparam logic [CNT_W-1:0] CNT_ONE = 17'd1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_OVER      = 3'd4
   } game_state_e;

   // Clamped at the floor; the subtraction is only taken when it cannot wrap.
   function automatic logic [CNT_W-1:0] step_period(
      input logic [LEVEL_W-1:0] level,
      input int unsigned        init_p,
      input int unsigned        dec_p,
      input int unsigned        floor_p
   );
      int unsigned red;
      int unsigned per;
      red = {{(32-LEVEL_W){1'b0}}, level} * dec_p;
      if (red >= init_p) begin
         per = floor_p;
      end else if ((init_p - red) < floor_p) begin
         per = floor_p;
      end else begin
         per = init_p - red;
      end
      return per[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/second_game_scheduler_step_timer.sv
// Obstacle step generator: counts PLAY cycles and pulses once per
// level-dependent period.
module step_timer
   import game_pkg::*;
#(
   parameter int unsigned TICK_PERIOD_INIT = 32'd32768,
   parameter int unsigned TICK_PERIOD_DEC  = 32'd2048,
   parameter int unsigned TICK_PERIOD_MIN  = 32'd8192
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               clr,
   input  logic               en,
   input  logic               leaving,
   input  logic [LEVEL_W-1:0] level,
   output logic               step
);

   logic [CNT_W-1:0] period_s;
   logic             wrap_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             step_q, step_d;

   // Counter advance and wrap; >= catches a period that shrank under the count.
   always_comb begin
      period_s = step_period(level, TICK_PERIOD_INIT, TICK_PERIOD_DEC, TICK_PERIOD_MIN);
      wrap_s   = (cnt_q >= (period_s - CNT_ONE));
      cnt_d    = cnt_q;
      step_d   = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (!wrap_s) begin
            cnt_d = cnt_q + CNT_ONE;
         end else if (leaving) begin
            // Hold at the wrap point so the step fires on return to PLAY.
            cnt_d = cnt_q;
         end else begin
            cnt_d  = '0;
            step_d = 1'b1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter and step pulse registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         step_q <= step_d;
      end
   end

   assign step = step_q;

endmodule

// File: rtl/second_game_scheduler.sv
// Game flow sequencer: IDLE/COUNTDOWN/PLAY/PAUSE/OVER, score and level
// bookkeeping, engine reset/pause control and obstacle step generation.
module second_game_scheduler
   import game_pkg::*;
#(
   parameter int unsigned TICK_PERIOD_INIT = 32'd32768,
   parameter int unsigned TICK_PERIOD_DEC  = 32'd2048,
   parameter int unsigned TICK_PERIOD_MIN  = 32'd8192,
   parameter int unsigned LEVEL_UP_SCORE   = 32'd5,
   parameter int unsigned COUNTDOWN_FRAMES = 32'd180,
   parameter int unsigned OVER_HOLD_FRAMES = 32'd120
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                i_start,
   input  logic                i_pause_btn,
   input  logic                i_frame_tick,
   input  logic                i_is_lose,
   input  logic                i_obstacle_passed,
   output logic                o_engine_rst_n,
   output logic                o_is_pause,
   output logic                o_step,
   output logic [SCORE_W-1:0]  o_score,
   output logic [LEVEL_W-1:0]  o_level,
   output logic [2:0]          o_state
);

   localparam logic [FRAME_W-1:0] CD_LAST   = FRAME_W'(COUNTDOWN_FRAMES - 32'd1);
   localparam logic [FRAME_W-1:0] OVER_LAST = FRAME_W'(OVER_HOLD_FRAMES - 32'd1);
   localparam logic [SCORE_W-1:0] LVL_LAST  = SCORE_W'(LEVEL_UP_SCORE - 32'd1);

   game_state_e        state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] lvl_cnt_q, lvl_cnt_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               eng_rst_n_q, eng_rst_n_d;
   logic               is_pause_q, is_pause_d;
   logic               enter_cd_s;

   // Next state, frame-hold counting and score/level updates.
   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      score_d    = score_q;
      lvl_cnt_d  = lvl_cnt_q;
      level_d    = level_q;
      enter_cd_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d    = ST_COUNTDOWN;
               enter_cd_s = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_COUNTDOWN: begin
            if (i_frame_tick && (frame_q >= CD_LAST)) begin
               state_d = ST_PLAY;
               frame_d = '0;
            end else if (i_frame_tick) begin
               frame_d = frame_q + 16'd1;
            end else begin
               frame_d = frame_q;
            end
         end
         ST_PLAY: begin
            if (i_is_lose) begin
               state_d = ST_OVER;
               frame_d = '0;
            end else if (i_pause_btn) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = state_q;
            end
         end
         ST_PAUSE: begin
            if (i_pause_btn) begin
               state_d = ST_PLAY;
            end else begin
               state_d = state_q;
            end
         end
         ST_OVER: begin
            if (i_start) begin
               state_d    = ST_COUNTDOWN;
               enter_cd_s = 1'b1;
            end else if (i_frame_tick && (frame_q >= OVER_LAST)) begin
               state_d = ST_IDLE;
               frame_d = '0;
            end else if (i_frame_tick) begin
               frame_d = frame_q + 16'd1;
            end else begin
               frame_d = frame_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            frame_d = '0;
         end
      endcase

      if (enter_cd_s) begin
         frame_d   = '0;
         score_d   = '0;
         lvl_cnt_d = '0;
         level_d   = '0;
      end else if ((state_q == ST_PLAY) && i_obstacle_passed && (score_q != 16'hFFFF)) begin
         score_d = score_q + 16'd1;
         // lvl_cnt tracks score modulo LEVEL_UP_SCORE without a divider.
         if (lvl_cnt_q >= LVL_LAST) begin
            lvl_cnt_d = '0;
            level_d   = (level_q == 4'hF) ? level_q : (level_q + 4'd1);
         end else begin
            lvl_cnt_d = lvl_cnt_q + 16'd1;
         end
      end else begin
         score_d = score_q;
      end

      eng_rst_n_d = !enter_cd_s;
      is_pause_d  = (state_d != ST_PLAY);
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= ST_IDLE;
         frame_q     <= '0;
         score_q     <= '0;
         lvl_cnt_q   <= '0;
         level_q     <= '0;
         eng_rst_n_q <= 1'b0;
         is_pause_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         score_q     <= score_d;
         lvl_cnt_q   <= lvl_cnt_d;
         level_q     <= level_d;
         eng_rst_n_q <= eng_rst_n_d;
         is_pause_q  <= is_pause_d;
      end
   end

   step_timer #(
      .TICK_PERIOD_INIT (TICK_PERIOD_INIT),
      .TICK_PERIOD_DEC  (TICK_PERIOD_DEC),
      .TICK_PERIOD_MIN  (TICK_PERIOD_MIN)
   ) u_step_timer (
      .clk     (clk),
      .arst_n  (arst_n),
      .clr     (enter_cd_s),
      .en      (state_q == ST_PLAY),
      .leaving (state_d != ST_PLAY),
      .level   (level_q),
      .step    (o_step)
   );

   assign o_engine_rst_n = eng_rst_n_q;
   assign o_is_pause     = is_pause_q;
   assign o_score        = score_q;
   assign o_level        = level_q;
   assign o_state        = state_q;

endmodule

// File: doc/second_game_scheduler.md
SECOND_GAME_SCHEDULER -- requirements
Module: second_game_scheduler

Interface
REQ-001 The module SHALL expose parameter TICK_PERIOD_INIT, default 32768, meaning the initial clk cycles per obstacle step.
REQ-002 The module SHALL expose parameter TICK_PERIOD_DEC, default 2048, meaning the step-period reduction per level.
REQ-003 The module SHALL expose parameter TICK_PERIOD_MIN, default 8192, meaning the floor of the step period.
REQ-004 The module SHALL expose parameter LEVEL_UP_SCORE, default 5, meaning the obstacles passed per level increment.
REQ-005 The module SHALL expose parameter COUNTDOWN_FRAMES, default 180, meaning the i_frame_tick pulses spent in COUNTDOWN.
REQ-006 The module SHALL expose parameter OVER_HOLD_FRAMES, default 120, meaning the i_frame_tick pulses spent in OVER.
REQ-007 The module SHALL have these ports, clock and reset first:
  clk  in  1  system clock
  arst_n  in  1  reset, asynchronous, active-low
  i_start  in  1  single-cycle start-button pulse
  i_pause_btn  in  1  single-cycle pause-toggle pulse
  i_frame_tick  in  1  single-cycle pulse, one per video frame
  i_is_lose  in  1  collision flag from the game engine
  i_obstacle_passed  in  1  single-cycle pulse when an obstacle leaves the field
  o_engine_rst_n  out  1  active-low synchronous reset to the engine
  o_is_pause  out  1  freezes the engine
  o_step  out  1  single-cycle obstacle-advance enable
  o_score  out  16  obstacles passed in the current game
  o_level  out  4  difficulty level
  o_state  out  3  current FSM state encoding

Function
REQ-008 The FSM SHALL have states IDLE=0, COUNTDOWN=1, PLAY=2, PAUSE=3, OVER=4.
REQ-009 In IDLE, i_start SHALL move the FSM to COUNTDOWN on the next cycle; all other inputs SHALL be ignored.
REQ-010 On entry to COUNTDOWN, o_engine_rst_n SHALL be 0 for exactly one cycle, and score, level and the step counter SHALL clear.
REQ-011 COUNTDOWN SHALL last COUNTDOWN_FRAMES i_frame_tick pulses and then go to PLAY; i_pause_btn and i_is_lose SHALL be ignored in COUNTDOWN.
REQ-012 In PLAY, i_is_lose=1 SHALL go to OVER; otherwise i_pause_btn SHALL go to PAUSE. When both are asserted in the same cycle, lose SHALL win.
REQ-013 In PAUSE, i_pause_btn SHALL return the FSM to PLAY; the step counter SHALL hold its value and not reset.
REQ-014 OVER SHALL last OVER_HOLD_FRAMES i_frame_tick pulses and then go to IDLE. i_start in OVER SHALL go directly to COUNTDOWN.
REQ-015 o_is_pause SHALL be 1 in every state except PLAY.
REQ-016 Step period P SHALL be max(TICK_PERIOD_INIT - o_level*TICK_PERIOD_DEC, TICK_PERIOD_MIN), computed at 17-bit width without underflow.
REQ-017 In PLAY, a 17-bit counter SHALL increment each cycle. When it reaches P-1, o_step SHALL pulse for that cycle and the counter SHALL wrap to 0.
REQ-018 o_step SHALL be 0 outside PLAY.
REQ-019 When the level drops P below the current count, the counter SHALL wrap on the next cycle.
REQ-020 In PLAY, i_obstacle_passed SHALL increment o_score, saturating at 16'hFFFF. The pulse SHALL be ignored in other states.
REQ-021 When an increment makes o_score a nonzero multiple of LEVEL_UP_SCORE, o_level SHALL increment in the same cycle, saturating at 15.
REQ-022 Score and level SHALL hold their values through PAUSE, OVER and IDLE until the next COUNTDOWN entry.
REQ-023 All outputs SHALL be registered, with single-cycle latency from the input event.

Reset
REQ-024 While arst_n=0, the block SHALL force: state IDLE, o_engine_rst_n=0, o_is_pause=1, o_step=0, o_score=0, o_level=0, and all counters 0.
REQ-025 The first clk edge after reset release SHALL drive o_engine_rst_n=1.
REQ-026 Reset asserted mid-game SHALL abort immediately to the REQ-024 values.

Structure
REQ-027 The state enum, its 3-bit encoding and the score/level widths SHALL live in shared package game_pkg.
REQ-028 The step generator (REQ-016 to REQ-019) SHALL be a sub-module named step_timer, with inputs en, level and output step.

Verification
REQ-029 Reset, then i_start, then 180 frame ticks: o_engine_rst_n is low for exactly one cycle, o_state goes 1->2, and the first o_step arrives 32768 cycles after PLAY entry.
REQ-030 Drive i_pause_btn at counter=1000 in PLAY, wait 5000 cycles, pause again: the next o_step arrives 31767 cycles after resume.
REQ-031 Drive i_pause_btn and i_is_lose in the same PLAY cycle: o_state=4, o_is_pause=1, no further o_step; after 120 frame ticks o_state=0.
REQ-032 Apply 80 i_obstacle_passed pulses: o_level=15 saturates, and the step period equals 8192 (min floor) from level 12 onward.
REQ-033 Apply arst_n=0 mid-PLAY with score=7: all outputs take the REQ-024 values asynchronously, before the next clk edge.
REQ-034 i_start during OVER: the FSM goes directly to COUNTDOWN, score clears to 0, and the one-cycle engine reset pulse is observed.
